// File: rtl/mem_port_arbiter.sv
// Purpose : shares the byte-wide memory_control port between instruction fetch and load/store.
// Latency : request sampled in IDLE -> mc_start next cycle -> done one cycle after mc_done (3 cycles + memory latency).
// Backpres: requesters hold req/operands until their done pulse; a losing requester simply waits.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   if_req/if_addr -> if_done/if_rdata          - fetch requester (always word mode)
//   d_req/d_we/d_addr/d_mode/d_wdata -> d_done/d_rdata - load/store requester
//   mc_start/mc_address/mc_mode/mc_write_data   - command to memory_control
//   mc_done/mc_active/mc_read_data              - status/result from memory_control
//   mem_we                       - byte-memory write strobe (data stores only)
//   grant                        - 01 fetch owns port, 10 data owns port, 00 idle
//   busy                         - high whenever not idle
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_mode,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        mc_start,
  output logic [31:0] mc_address,
  output logic [2:0]  mc_mode,
  output logic [31:0] mc_write_data,
  input  logic        mc_done,
  input  logic        mc_active,
  input  logic [31:0] mc_read_data,
  output logic        mem_we,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;
  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);
  localparam logic [2:0] MODE_WORD = 3'b010;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= GNT_NONE;
      streak_q   <= 4'd0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Next-state and arbitration
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = ISSUE;
          if (d_req && !(if_req && (streak_q >= STREAK_LIMIT))) begin
            grant_d = GNT_D;
            // Data only wins against a waiting fetch while below the limit,
            // so the increment can never exceed MAX_STREAK.
            streak_d = if_req ? (streak_q + 4'd1) : 4'd0;
          end else begin
            grant_d  = GNT_IF;
            streak_d = 4'd0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // mc_done is only meaningful here; elsewhere it is ignored.
        if (mc_done) begin
          state_d = RESP;
          if (grant_q == GNT_D) d_rdata_d  = mc_read_data;
          else                  if_rdata_d = mc_read_data;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    grant         = grant_q;
    busy          = (state_q != IDLE);
    mc_start      = (state_q == ISSUE);
    if_done       = (state_q == RESP) && (grant_q == GNT_IF);
    d_done        = (state_q == RESP) && (grant_q == GNT_D);
    mem_we        = (grant_q == GNT_D) && d_we && (state_q == WAIT) && mc_active;
    mc_address    = 32'd0;
    mc_mode       = 3'd0;
    mc_write_data = 32'd0;
    // grant_q is only non-zero from ISSUE through RESP, so the mux is
    // stable for the whole transfer and zero when idle.
    if (grant_q == GNT_D) begin
      mc_address    = d_addr;
      mc_mode       = d_mode;
      mc_write_data = d_wdata;
    end else if (grant_q == GNT_IF) begin
      mc_address    = if_addr;
      mc_mode       = MODE_WORD;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;
  localparam logic [1:0] GNT_IF = 2'b01;
  localparam logic [1:0] GNT_D  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [2:0]  d_mode;
  logic        if_done, d_done, mc_start, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mc_address, mc_write_data;
  logic [2:0]  mc_mode;
  logic [1:0]  grant;
  logic        mc_done = 1'b0, mc_active = 1'b0;
  logic [31:0] mc_read_data = 32'd0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mode(d_mode), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mc_start(mc_start), .mc_address(mc_address), .mc_mode(mc_mode),
    .mc_write_data(mc_write_data), .mc_done(mc_done), .mc_active(mc_active),
    .mc_read_data(mc_read_data), .mem_we(mem_we), .grant(grant), .busy(busy)
  );

  function automatic int nbytes(input logic [2:0] mode);
    return (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] mode);
    case (mode)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b100:  return {24'd0, v[7:0]};
      3'b101:  return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Behavioural memory_control + byte memory: one byte per active cycle,
  // done pulse right after the last byte.
  logic [7:0]  mem [0:1023];
  logic        m_on;
  logic [31:0] m_addr, m_wdata, m_buf;
  logic [2:0]  m_mode;
  int          m_idx;

  always @(posedge clk) begin : mc_model
    logic [31:0] acc;
    logic [9:0]  a;
    mc_done <= 1'b0;
    if (rst) begin
      m_on      <= 1'b0;
      mc_active <= 1'b0;
      m_idx     <= 0;
      m_buf     <= 32'd0;
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h100] <= 8'hEF; mem[10'h101] <= 8'hBE; mem[10'h102] <= 8'hAD; mem[10'h103] <= 8'hDE;
      mem[10'h180] <= 8'h80;
      mem[10'h300] <= 8'h0D; mem[10'h301] <= 8'hF0; mem[10'h302] <= 8'hFE; mem[10'h303] <= 8'hCA;
    end else if (m_on) begin
      a   = 10'(m_addr + 32'(m_idx));
      acc = m_buf;
      acc[8*m_idx +: 8] = mem[a];
      if (mem_we) mem[a] <= m_wdata[8*m_idx +: 8];
      m_buf <= acc;
      m_idx <= m_idx + 1;
      if (m_idx == nbytes(m_mode) - 1) begin
        m_on         <= 1'b0;
        mc_active    <= 1'b0;
        mc_done      <= 1'b1;
        mc_read_data <= extend(acc, m_mode);
      end
    end else if (mc_start) begin
      m_on      <= 1'b1;
      mc_active <= 1'b1;
      m_addr    <= mc_address;
      m_mode    <= mc_mode;
      m_wdata   <= mc_write_data;
      m_idx     <= 0;
      m_buf     <= 32'd0;
    end
  end

  int illegal_we  = 0;
  int done_pulses = 0;
  always @(posedge clk) begin
    if (mem_we && !mc_active) illegal_we <= illegal_we + 1;
    if (if_done || d_done) done_pulses <= done_pulses + 1;
  end

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic        we;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_txn = 0;
  logic [31:0] exp_if_rdata = 32'd0;
  logic [31:0] exp_d_rdata  = 32'd0;
  bit          keep_if = 0, keep_d = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] g, input logic [31:0] ad, input logic [2:0] md,
                      input logic [31:0] wd, input logic we, input logic chk, input logic [31:0] rd);
    exp_t e;
    e.gnt = g; e.addr = ad; e.mode = md; e.wdata = wd; e.we = we; e.chk = chk; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Follows one transfer from the current cycle to its done pulse, then
  // steps into the following IDLE cycle.
  task automatic wait_done(input int budget, input int drop_cyc);
    exp_t e;
    int   starts, start_cyc, we_cnt;
    bit   got;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb[0];
    starts = 0; start_cyc = 0; we_cnt = 0; got = 0;
    for (int cyc = 0; cyc < budget && !got; cyc++) begin
      if (cyc == drop_cyc) d_req = 1'b0;
      if (mc_start) begin
        starts++;
        start_cyc = cyc;
        check("issue_grant", 32'(grant), 32'(e.gnt));
        check("issue_addr", mc_address, e.addr);
        check("issue_mode", 32'(mc_mode), 32'(e.mode));
        check("issue_wdata", mc_write_data, e.wdata);
      end
      if (mem_we) we_cnt++;
      if (if_done || d_done) begin
        got = 1;
        void'(sb.pop_front());
        n_txn++;
        if (e.gnt == GNT_D) exp_d_rdata  = e.chk ? e.rdata : mc_read_data;
        else                exp_if_rdata = e.rdata;
        check("done_grant", 32'(grant), 32'(e.gnt));
        check("if_done", 32'(if_done), 32'(e.gnt == GNT_IF));
        check("d_done", 32'(d_done), 32'(e.gnt == GNT_D));
        check("if_rdata", if_rdata, exp_if_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        check("start_pulses", 32'(starts), 32'd1);
        check("start_to_done", 32'(cyc - start_cyc), 32'(nbytes(e.mode) + 2));
        check("mem_we_cycles", 32'(we_cnt), e.we ? 32'(nbytes(e.mode)) : 32'd0);
        if (e.gnt == GNT_IF && !keep_if) if_req = 1'b0;
        if (e.gnt == GNT_D && !keep_d) d_req = 1'b0;
      end
      step();
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int pulses;
    // Reset with both requests pending
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h100; d_we = 1'b0; d_addr = 32'h180; d_mode = 3'b000; d_wdata = 32'd0;
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_mc_start", 32'(mc_start), 32'd0);
    check("rst_dones", 32'({if_done, d_done}), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mc_addr", mc_address, 32'd0);
    check("rst_mc_mode", 32'(mc_mode), 32'd0);
    check("rst_mc_wdata", mc_write_data, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    step();
    check("rst2_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    check("idle_after_rst", 32'(busy), 32'd0);
    // Signed byte load wins, then the waiting fetch runs alone
    push(GNT_D, 32'h180, 3'b000, 32'd0, 1'b0, 1'b1, 32'hFFFF_FF80);
    push(GNT_IF, 32'h100, 3'b010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    step();
    check("issue_2nd_cycle", 32'(mc_start), 32'd1);
    wait_done(50, -1);
    wait_done(50, -1);

    // Unsigned byte load
    d_mode = 3'b100; d_req = 1'b1;
    push(GNT_D, 32'h180, 3'b100, 32'd0, 1'b0, 1'b1, 32'h0000_0080);
    wait_done(50, -1);

    // Word store
    d_we = 1'b1; d_addr = 32'h200; d_mode = 3'b010; d_wdata = 32'h1122_3344; d_req = 1'b1;
    push(GNT_D, 32'h200, 3'b010, 32'h1122_3344, 1'b1, 1'b0, 32'd0);
    wait_done(50, -1);
    check("store_b0", 32'(mem[10'h200]), 32'h44);
    check("store_b1", 32'(mem[10'h201]), 32'h33);
    check("store_b2", 32'(mem[10'h202]), 32'h22);
    check("store_b3", 32'(mem[10'h203]), 32'h11);
    d_we = 1'b0; d_wdata = 32'd0;

    // Signed half load, request dropped while waiting
    d_addr = 32'h302; d_mode = 3'b001; d_req = 1'b1;
    push(GNT_D, 32'h302, 3'b001, 32'd0, 1'b0, 1'b1, 32'hFFFF_CAFE);
    wait_done(50, 3);

    // Reset while in WAIT
    d_addr = 32'h180; d_mode = 3'b000; d_req = 1'b1;
    step();
    check("abort_issue", 32'(mc_start), 32'd1);
    step();
    check("abort_wait_grant", 32'(grant), 32'(GNT_D));
    pulses = done_pulses;
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_d_done", 32'(d_done), 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    check("abort_if_rdata", if_rdata, 32'd0);
    exp_d_rdata = 32'd0; exp_if_rdata = 32'd0;
    for (int i = 0; i < 8; i++) step();
    check("abort_no_done", 32'(done_pulses), 32'(pulses));

    // Fresh request after abort
    d_mode = 3'b100; d_req = 1'b1;
    push(GNT_D, 32'h180, 3'b100, 32'd0, 1'b0, 1'b1, 32'h0000_0080);
    wait_done(50, -1);

    // Contention: both held, streak limit lets fetch in after 4 data grants
    d_addr = 32'h300; d_mode = 3'b010; if_req = 1'b1; d_req = 1'b1;
    keep_if = 1; keep_d = 1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < MAX_STREAK; k++)
        push(GNT_D, 32'h300, 3'b010, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D);
      push(GNT_IF, 32'h100, 3'b010, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    end
    for (int k = 0; k < 2 * (MAX_STREAK + 1); k++) wait_done(50, -1);
    if_req = 1'b0; d_req = 1'b0;
    step(); step();
    check("final_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("mem_we_outside_active", 32'(illegal_we), 32'd0);
    check("done_pulse_total", 32'(done_pulses), 32'(n_txn));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
